multu_unit: RTL and testbench
=============================

MULTU_UNIT -- requirements
Module: multu_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  MULTU issued from EX stage; operands valid this cycle.
REQ-005 SHALL have port cancel  input  1  pipeline flush; aborts an in-flight multiply.
REQ-006 SHALL have port src_a  input  WIDTH  multiplicand (rs value), unsigned.
REQ-007 SHALL have port src_b  input  WIDTH  multiplier (rt value), unsigned.
REQ-008 SHALL have port busy  output  1  multiply in progress; pipeline stalls MFHI/MFLO/MULTU while high.
REQ-009 SHALL have port done  output  1  one-cycle pulse; HI/LO hold the new result.
REQ-010 SHALL have port hi  output  WIDTH  HI register, feeds MFHI.
REQ-011 SHALL have port lo  output  WIDTH  LO register, feeds MFLO.

Function
REQ-012 SHALL implement states IDLE, RUN, DONE.
REQ-013 SHALL, in IDLE or DONE with start=1 at an edge, latch src_a/src_b, clear the accumulator and iteration count, and enter RUN.
REQ-014 SHALL, in RUN, perform one shift-add step per cycle: if the multiplier LSB is 1, add the multiplicand into the upper half; then shift the {carry, accumulator, multiplier} value right by 1.
REQ-015 SHALL keep the WIDTH+1-bit add carry, so the 2*WIDTH product is exact for all unsigned inputs; no overflow or exception.
REQ-016 SHALL leave RUN after exactly WIDTH steps; at that edge it SHALL load hi=product[2W-1:W] and lo=product[W-1:0], then enter DONE.
REQ-017 SHALL hold done=1 for the single DONE cycle; the first DONE cycle is 33 cycles after the start edge for WIDTH=32.
REQ-018 SHALL go from DONE to IDLE when start=0, or back to RUN with new operands when start=1 (back-to-back).
REQ-019 SHALL drive busy=1 in every RUN cycle and busy=0 in IDLE and DONE.
REQ-020 SHALL ignore start while in RUN; the operands and count stay unchanged.
REQ-021 SHALL, with cancel=1 at an edge in RUN, return to IDLE, leave hi/lo unchanged, and not pulse done.
REQ-022 SHALL give cancel priority over start when both are asserted in the same cycle, and SHALL NOT start a new operation.
REQ-023 SHALL hold hi/lo stable except at the RUN->DONE edge.

Reset
REQ-024 SHALL, on rst=0, asynchronously force state=IDLE, busy=0, done=0, hi=0, lo=0, and clear the accumulator and count.
REQ-025 SHALL, on reset during RUN, discard the partial product; no done pulse follows reset release.
REQ-026 SHALL ignore start until the first rising edge after rst returns high.

Structure
REQ-027 SHALL take the state enumeration and the default WIDTH constant from the shared CPU package mips_pkg.
REQ-028 SHALL be a single module with no sub-modules; the iteration counter is log2(WIDTH)+1 bits wide.

Verification
REQ-029 SHALL cover: src_a=7, src_b=6, start -> done after 33 cycles, hi=0x00000000, lo=0x0000002A.
REQ-030 SHALL cover: src_a=src_b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-031 SHALL cover: start 3*5, then start 9*9 pulsed at cycle 10 -> busy stays high, result hi=0, lo=15, and a single done pulse.
REQ-032 SHALL cover: after a result of lo=15, start 4*4 then cancel at cycle 12 -> busy=0 next cycle, lo stays 15, no done pulse.
REQ-033 SHALL cover: start 2*3, then rst=0 at cycle 20 -> hi=lo=0 immediately, state IDLE, no done after release.
REQ-034 SHALL cover: start 2*2, then start 3*3 in the DONE cycle -> lo=4 at the first done, lo=9 at the second done 33 cycles later.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg -- shared CPU definitions used by the multiply unit.
// Provides the default operand width, the multiplier state encoding and a
// helper that sizes the iteration counter so it can hold the value WIDTH.
package mips_pkg;

    localparam int MULT_WIDTH = 32;

    typedef enum logic [1:0] {
        MULT_IDLE = 2'd0,
        MULT_RUN  = 2'd1,
        MULT_DONE = 2'd2
    } mult_state_t;

    // Counter must reach WIDTH itself (one extra cycle to unload the product).
    function automatic int mult_cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/multu_unit.sv
// multu_unit -- iterative unsigned shift-add multiplier (MIPS MULTU).
// Ports:
//   clk    : clock, all state updates on its rising edge
//   rst    : asynchronous active-low reset
//   start  : MULTU issued, src_a/src_b valid this cycle
//   cancel : pipeline flush, aborts an in-flight multiply
//   src_a  : multiplicand (unsigned)
//   src_b  : multiplier (unsigned)
//   busy   : high in every RUN cycle
//   done   : one-cycle pulse when hi/lo hold a new result
//   hi/lo  : upper/lower halves of the 2*WIDTH product
// Timing: start edge enters RUN; WIDTH add/shift steps follow, then one more
// RUN edge unloads the product into hi/lo, so done rises WIDTH+1 edges after
// the start edge.
module multu_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cancel,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int                CNT_W    = mult_cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    mult_state_t      state_r, state_nxt_s;
    logic [WIDTH-1:0] mcand_r, mcand_nxt_s;
    logic [WIDTH-1:0] acc_r, acc_nxt_s;       // upper half of running product
    logic [WIDTH-1:0] mplier_r, mplier_nxt_s; // multiplier, shifts into lower half
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic [WIDTH-1:0] hi_r, hi_nxt_s;
    logic [WIDTH-1:0] lo_r, lo_nxt_s;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH:0]   sum_s;                  // carry kept so the product is exact

    // Partial-product add for the current step.
    always_comb begin
        if (mplier_r[0]) begin
            sum_s = {1'b0, acc_r} + {1'b0, mcand_r};
        end else begin
            sum_s = {1'b0, acc_r};
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_nxt_s  = state_r;
        mcand_nxt_s  = mcand_r;
        acc_nxt_s    = acc_r;
        mplier_nxt_s = mplier_r;
        cnt_nxt_s    = cnt_r;
        hi_nxt_s     = hi_r;
        lo_nxt_s     = lo_r;
        case (state_r)
            MULT_RUN: begin
                // start is ignored here; only cancel or completion leave RUN.
                if (cancel) begin
                    state_nxt_s = MULT_IDLE;
                end else if (cnt_r == LAST_CNT) begin
                    hi_nxt_s    = acc_r;
                    lo_nxt_s    = mplier_r;
                    state_nxt_s = MULT_DONE;
                end else begin
                    // Shift {carry, acc, mplier} right by one.
                    acc_nxt_s    = sum_s[WIDTH:1];
                    mplier_nxt_s = {sum_s[0], mplier_r[WIDTH-1:1]};
                    cnt_nxt_s    = cnt_r + CNT_ONE;
                end
            end
            MULT_IDLE, MULT_DONE: begin
                // cancel wins over start and never launches an operation.
                if (cancel) begin
                    state_nxt_s = MULT_IDLE;
                end else if (start) begin
                    mcand_nxt_s  = src_a;
                    mplier_nxt_s = src_b;
                    acc_nxt_s    = '0;
                    cnt_nxt_s    = '0;
                    state_nxt_s  = MULT_RUN;
                end else begin
                    state_nxt_s = MULT_IDLE;
                end
            end
            default: begin
                state_nxt_s = MULT_IDLE;
            end
        endcase
    end

    // State, datapath and registered output flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= MULT_IDLE;
            mcand_r  <= '0;
            acc_r    <= '0;
            mplier_r <= '0;
            cnt_r    <= '0;
            hi_r     <= '0;
            lo_r     <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            mcand_r  <= mcand_nxt_s;
            acc_r    <= acc_nxt_s;
            mplier_r <= mplier_nxt_s;
            cnt_r    <= cnt_nxt_s;
            hi_r     <= hi_nxt_s;
            lo_r     <= lo_nxt_s;
            busy_r   <= (state_nxt_s == MULT_RUN);
            done_r   <= (state_nxt_s == MULT_DONE);
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_multu_unit.sv
// tb_multu_unit -- directed self-checking bench for multu_unit (WIDTH=32).
// Expected products are computed by the bench and queued at each start;
// they are popped and compared when done pulses.
module tb_multu_unit;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic         cancel;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int tests;
    int fails;
    int done_cnt;
    int snap;
    logic [63:0] exp_q[$];

    multu_unit #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .cancel (cancel),
        .src_a  (src_a),
        .src_b  (src_b),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial done_cnt = 0;
    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one start pulse; optionally queue the expected product.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
        src_a = a;
        src_b = b;
        start = 1'b1;
        cycle();
        start = 1'b0;
        if (push) exp_q.push_back({32'd0, a} * {32'd0, b});
    endtask

    // Wait (bounded) for done, check latency, busy coverage and the result.
    task automatic wait_done(input string tag, input int exp_lat);
        int lat;
        bit gap;
        logic [63:0] exp;
        lat = -1;
        gap = 1'b0;
        for (int i = 1; i <= exp_lat + 10; i++) begin
            cycle();
            if (done) begin
                lat = i;
                break;
            end
            if (!busy) gap = 1'b1;
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_busy_gap"}, {63'd0, gap}, 64'd0);
        check({tag, "_busy_in_done"}, {63'd0, busy}, 64'd0);
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        else exp = 64'bx;
        check({tag, "_product"}, {hi, lo}, exp);
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        rst    = 1'b0;
        start  = 1'b1;
        cancel = 1'b0;
        src_a  = 32'd5;
        src_b  = 32'd5;
        // start held during reset must have no effect
        repeat (3) cycle();
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        start = 1'b0;
        rst   = 1'b1;
        cycle();
        check("post_rst_busy", {63'd0, busy}, 64'd0);

        // 7 * 6
        start_op(32'd7, 32'd6, 1'b1);
        check("run_busy", {63'd0, busy}, 64'd1);
        wait_done("mul7x6", 33);
        check("mul7x6_lo", {32'd0, lo}, 64'h2A);
        cycle();
        check("done_single", {63'd0, done}, 64'd0);
        check("idle_busy", {63'd0, busy}, 64'd0);

        // max * max
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_done("mulmax", 33);
        check("mulmax_hi", {32'd0, hi}, 64'hFFFF_FFFE);
        check("mulmax_lo", {32'd0, lo}, 64'h1);
        cycle();

        // 3 * 5, with 9 * 9 pulsed at cycle 10 (ignored)
        snap = done_cnt;
        start_op(32'd3, 32'd5, 1'b1);
        repeat (9) cycle();
        src_a = 32'd9;
        src_b = 32'd9;
        start = 1'b1;
        cycle();
        start = 1'b0;
        check("ign_busy", {63'd0, busy}, 64'd1);
        check("hold_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        wait_done("mul3x5", 23);
        repeat (2) cycle();
        check("mul3x5_done_pulses", 64'(done_cnt - snap), 64'd1);

        // 4 * 4 cancelled at cycle 12
        snap = done_cnt;
        start_op(32'd4, 32'd4, 1'b0);
        repeat (11) cycle();
        cancel = 1'b1;
        cycle();
        cancel = 1'b0;
        check("cancel_busy", {63'd0, busy}, 64'd0);
        repeat (40) cycle();
        check("cancel_hilo", {hi, lo}, 64'd15);
        check("cancel_no_done", 64'(done_cnt - snap), 64'd0);

        // cancel beats start in IDLE
        src_a  = 32'd6;
        src_b  = 32'd6;
        start  = 1'b1;
        cancel = 1'b1;
        cycle();
        start  = 1'b0;
        cancel = 1'b0;
        check("cancel_prio_busy", {63'd0, busy}, 64'd0);
        repeat (40) cycle();
        check("cancel_prio_no_done", 64'(done_cnt - snap), 64'd0);

        // 2 * 3 interrupted by reset at cycle 20
        snap = done_cnt;
        start_op(32'd2, 32'd3, 1'b0);
        repeat (19) cycle();
        rst = 1'b0;
        #1;
        check("async_rst_hilo", {hi, lo}, 64'd0);
        check("async_rst_busy", {63'd0, busy}, 64'd0);
        repeat (2) cycle();
        rst = 1'b1;
        repeat (40) cycle();
        check("rst_no_done", 64'(done_cnt - snap), 64'd0);
        check("rst_idle_busy", {63'd0, busy}, 64'd0);

        // 2 * 2 then 3 * 3 issued in the DONE cycle
        start_op(32'd2, 32'd2, 1'b1);
        wait_done("mul2x2", 33);
        check("mul2x2_lo", {32'd0, lo}, 64'd4);
        start_op(32'd3, 32'd3, 1'b1);
        check("b2b_busy", {63'd0, busy}, 64'd1);
        check("b2b_hold_lo", {32'd0, lo}, 64'd4);
        wait_done("mul3x3", 33);
        check("mul3x3_lo", {32'd0, lo}, 64'd9);
        cycle();
        check("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
